// File: rtl/tx_ffe_drv.sv
// Transmit stage: bit source (zero / PRBS7 / PRBS31 / 16-bit pattern), 3-tap FFE and amplitude scaling.
// Define TX_DRV_ERR_INJ_EN to add the inj_i single-bit error injection port.
module tx_ffe_drv #(
    parameter int WIDTH     = 16,
    parameter int COEF_W    = 8,
    parameter int COEF_FRAC = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cke,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [15:0]              pat_i,
    input  logic [WIDTH-2:0]         amp_i,
    input  logic signed [COEF_W-1:0] tap_pre,
    input  logic signed [COEF_W-1:0] tap_main,
    input  logic signed [COEF_W-1:0] tap_post,
    input  logic                     clr_sat_i,
`ifdef TX_DRV_ERR_INJ_EN
    input  logic                     inj_i,
`endif
    output logic signed [WIDTH-1:0]  out,
    output logic                     out_valid,
    output logic                     bit_o,
    output logic                     sat_o
);

    localparam int SUM_W  = COEF_W + 2;
    localparam int PROD_W = SUM_W + WIDTH;
    localparam logic [6:0]  SEED7  = 7'h7F;
    localparam logic [30:0] SEED31 = 31'h7FFF_FFFF;

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_PRBS7  = 2'd1,
        MODE_PRBS31 = 2'd2,
        MODE_PAT    = 2'd3
    } mode_e;

    // Bit source and cursor shift register
    logic [2:0]  b_q, b_d;
    logic [6:0]  l7_q, l7_d;
    logic [30:0] l31_q, l31_d;
    logic [3:0]  ptr_q, ptr_d;
    mode_e       mode_q, mode_d;
    logic        adv_q, adv_d;
`ifdef TX_DRV_ERR_INJ_EN
    logic        inj_q, inj_d;
    logic        inj_armed;
`endif

    // Stage 1: tap sum
    logic                    v1_q, v1_d;
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic                    bs1_q, bs1_d;

    // Stage 2: scaled, saturated output
    logic signed [WIDTH-1:0] out_q, out_d;
    logic                    bit_q, bit_d;
    logic                    valid_q, valid_d;
    logic                    sat_q, sat_d;

    // Combinational temporaries
    logic                     adv;
    logic [6:0]               l7_eff;
    logic [30:0]              l31_eff;
    logic                     fb7, fb31;
    logic [3:0]               ptr_eff;
    logic                     g_raw, g;
    logic signed [SUM_W-1:0]  pre_x, main_x, post_x;
    logic signed [PROD_W-1:0] sum_ext, amp_ext, prod, sh;
    logic                     ovf;

    always_comb begin
        adv     = cke & en;
        l7_eff  = (l7_q == '0) ? SEED7 : l7_q;
        l31_eff = (l31_q == '0) ? SEED31 : l31_q;
        fb7     = l7_eff[6] ^ l7_eff[5];
        fb31    = l31_eff[30] ^ l31_eff[27];
        // Entering pattern mode restarts the pattern at bit 0, even on an advance edge.
        ptr_eff = ((mode == MODE_PAT) && (mode_q != MODE_PAT)) ? 4'd0 : ptr_q;

        case (mode)
            MODE_PRBS7:  g_raw = fb7;
            MODE_PRBS31: g_raw = fb31;
            MODE_PAT:    g_raw = pat_i[ptr_eff];
            default:     g_raw = 1'b0;
        endcase

`ifdef TX_DRV_ERR_INJ_EN
        inj_armed = inj_q | inj_i;
        g         = g_raw ^ (adv & inj_armed);
        inj_d     = adv ? 1'b0 : inj_armed;
`else
        g         = g_raw;
`endif

        b_d    = adv ? {g, b_q[2:1]} : b_q;
        l7_d   = (adv && (mode == MODE_PRBS7)) ? {l7_eff[5:0], fb7} : l7_q;
        l31_d  = (adv && (mode == MODE_PRBS31)) ? {l31_eff[29:0], fb31} : l31_q;
        ptr_d  = (adv && (mode == MODE_PAT)) ? (ptr_eff + 4'd1) : ptr_eff;
        mode_d = mode_e'(mode);
        adv_d  = adv;

        // Stage 1 sees the shift register as it stands right after the advance.
        pre_x  = {{2{tap_pre[COEF_W-1]}}, tap_pre};
        main_x = {{2{tap_main[COEF_W-1]}}, tap_main};
        post_x = {{2{tap_post[COEF_W-1]}}, tap_post};
        v1_d   = adv_q;
        bs1_d  = adv_q ? b_q[1] : bs1_q;
        sum_d  = adv_q ? ((b_q[2] ? pre_x : -pre_x)
                        + (b_q[1] ? main_x : -main_x)
                        + (b_q[0] ? post_x : -post_x))
                       : sum_q;

        sum_ext = {{WIDTH{sum_q[SUM_W-1]}}, sum_q};
        amp_ext = {{(PROD_W-WIDTH+1){1'b0}}, amp_i};
        prod    = sum_ext * amp_ext;
        sh      = prod >>> COEF_FRAC;
        // In range only when every bit above the output sign bit copies it.
        ovf     = ~((&sh[PROD_W-1:WIDTH-1]) | ~(|sh[PROD_W-1:WIDTH-1]));

        out_d   = out_q;
        bit_d   = bit_q;
        valid_d = v1_q;
        sat_d   = sat_q & ~clr_sat_i;
        if (v1_q) begin
            bit_d = bs1_q;
            if (ovf) begin
                out_d = sh[PROD_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                sat_d = 1'b1;
            end else begin
                out_d = sh[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            b_q     <= '0;
            l7_q    <= SEED7;
            l31_q   <= SEED31;
            ptr_q   <= '0;
            mode_q  <= MODE_ZERO;
            adv_q   <= 1'b0;
`ifdef TX_DRV_ERR_INJ_EN
            inj_q   <= 1'b0;
`endif
            v1_q    <= 1'b0;
            sum_q   <= '0;
            bs1_q   <= 1'b0;
            out_q   <= '0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            b_q     <= b_d;
            l7_q    <= l7_d;
            l31_q   <= l31_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            adv_q   <= adv_d;
`ifdef TX_DRV_ERR_INJ_EN
            inj_q   <= inj_d;
`endif
            v1_q    <= v1_d;
            sum_q   <= sum_d;
            bs1_q   <= bs1_d;
            out_q   <= out_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            sat_q   <= sat_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;
    assign bit_o     = bit_q;
    assign sat_o     = sat_q;

endmodule

// File: tb/tb_tx_ffe_drv.sv
// Self-checking bench for tx_ffe_drv: a bit-history reference model predicts every out_valid word.
// Builds with or without TX_DRV_ERR_INJ_EN.
module tb_tx_ffe_drv;

    localparam int WIDTH  = 16;
    localparam int COEF_W = 8;

    logic                     clk = 1'b0;
    logic                     rst, cke, en, clr_sat_i, inj_i;
    logic [1:0]               mode;
    logic [15:0]              pat_i;
    logic [WIDTH-2:0]         amp_i;
    logic signed [COEF_W-1:0] tap_pre, tap_main, tap_post;
    logic signed [WIDTH-1:0]  out;
    logic                     out_valid, bit_o, sat_o;

    int checks = 0;
    int passed = 0;

    // Scoreboard entries are {bit_o, out}
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] got_q[$];

    // Reference model state: generator bit histories, pattern index, cursor bits
    int       h7[$];
    int       h31[$];
    int       mptr;
    int       mb2, mb1, mb0;
    bit       minj;
    bit       msat;
    logic [1:0] prev_mode;

    always #5 clk = ~clk;

    tx_ffe_drv dut (
        .clk       (clk),
        .rst       (rst),
        .cke       (cke),
        .en        (en),
        .mode      (mode),
        .pat_i     (pat_i),
        .amp_i     (amp_i),
        .tap_pre   (tap_pre),
        .tap_main  (tap_main),
        .tap_post  (tap_post),
        .clr_sat_i (clr_sat_i),
`ifdef TX_DRV_ERR_INJ_EN
        .inj_i     (inj_i),
`endif
        .out       (out),
        .out_valid (out_valid),
        .bit_o     (bit_o),
        .sat_o     (sat_o)
    );

    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) got_q.push_back({bit_o, out});
    end

    function automatic int sym(input int b, input int t);
        return (b != 0) ? t : -t;
    endfunction

    task automatic model_reset();
        h7.delete();
        h31.delete();
        for (int i = 0; i < 7; i++) h7.push_back(1);
        for (int i = 0; i < 31; i++) h31.push_back(1);
        mptr = 0; mb2 = 0; mb1 = 0; mb0 = 0;
        minj = 0; msat = 0; prev_mode = 2'd0;
        exp_q.delete();
        got_q.delete();
    endtask

    // New bit from the generator recurrences, then the FFE output the symbol should produce.
    task automatic model_adv();
        int g, sum;
        longint p, v;
        case (mode)
            2'd1: begin g = h7[0] ^ h7[1]; h7.push_back(g); void'(h7.pop_front()); end
            2'd2: begin g = h31[0] ^ h31[3]; h31.push_back(g); void'(h31.pop_front()); end
            2'd3: begin g = int'(pat_i[mptr]); mptr = (mptr + 1) % 16; end
            default: g = 0;
        endcase
        if (minj || inj_i) g = g ^ 1;
        minj = 0;
        mb0 = mb1; mb1 = mb2; mb2 = g;
        sum = sym(mb2, int'(tap_pre)) + sym(mb1, int'(tap_main)) + sym(mb0, int'(tap_post));
        p = longint'(sum) * longint'(amp_i);
        v = p >>> 6;
        if (v > 32767) begin v = 32767; msat = 1; end
        if (v < -32768) begin v = -32768; msat = 1; end
        exp_q.push_back({mb1[0], v[WIDTH-1:0]});
    endtask

    task automatic tick(input logic c);
        cke = c;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (mode == 2'd3 && prev_mode != 2'd3) mptr = 0;
            if (cke && en) model_adv();
            else if (inj_i) minj = 1;
            prev_mode = mode;
        end
        #1;
        cke = 1'b0; clr_sat_i = 1'b0; inj_i = 1'b0;
    endtask

    task automatic do_reset();
        en = 1'b1; mode = 2'd0; pat_i = 16'h0; amp_i = '0;
        tap_pre = '0; tap_main = '0; tap_post = '0;
        clr_sat_i = 1'b0; inj_i = 1'b0;
        rst = 1'b1;
        tick(1'b0);
        tick(1'b0);
        rst = 1'b0;
    endtask

    task automatic drain();
        repeat (5) tick(1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out !== '0) $display("FAIL reset_out got=%0d exp=0", out); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else passed++;
        checks++; if (bit_o !== 1'b0) $display("FAIL reset_bit got=%b exp=0", bit_o); else passed++;
        checks++; if (sat_o !== 1'b0) $display("FAIL reset_sat got=%b exp=0", sat_o); else passed++;
    endtask

    task automatic test_prbs7();
        logic [WIDTH:0] a, e;
        logic signed [WIDTH-1:0] v;
        int idx;
        do_reset();
        mode = 2'd1; tap_main = 8'sd64; amp_i = 15'd1000;
        tick(1'b1);
        checks++; if (out_valid !== 1'b0) $display("FAIL prbs7_lat1 got=%b exp=0", out_valid); else passed++;
        tick(1'b1);
        checks++; if (out_valid !== 1'b0) $display("FAIL prbs7_lat2 got=%b exp=0", out_valid); else passed++;
        tick(1'b1);
        checks++; if (out_valid !== 1'b1) $display("FAIL prbs7_lat3 got=%b exp=1", out_valid); else passed++;
        repeat (297) tick(1'b1);
        drain();
        for (int i = 0; i < 6; i++) begin
            v = got_q[i][WIDTH-1:0];
            checks++; if (v !== -16'sd1000) $display("FAIL prbs7_head[%0d] got=%0d exp=-1000", i, v); else passed++;
        end
        checks++;
        if (got_q.size() != 300) $display("FAIL prbs7_count got=%0d exp=300", got_q.size()); else passed++;
        idx = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (a !== e) $display("FAIL prbs7_stream[%0d] got bit=%b out=%0d exp bit=%b out=%0d",
                                  idx, a[WIDTH], $signed(a[WIDTH-1:0]), e[WIDTH], $signed(e[WIDTH-1:0]));
            else passed++;
            idx++;
        end
    endtask

    task automatic test_pattern();
        logic [WIDTH:0] a, e;
        int idx;
        do_reset();
        mode = 2'd3; pat_i = 16'hA5A5; tap_main = 8'sd64; amp_i = 15'd1000;
        for (int s = 0; s < 40; s++) begin
            tick(1'b1);
            repeat (3) tick(1'b0);
        end
        drain();
        checks++;
        if (got_q.size() != 40) $display("FAIL pattern_count got=%0d exp=40", got_q.size()); else passed++;
        idx = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (a !== e) $display("FAIL pattern_stream[%0d] got bit=%b out=%0d exp bit=%b out=%0d",
                                  idx, a[WIDTH], $signed(a[WIDTH-1:0]), e[WIDTH], $signed(e[WIDTH-1:0]));
            else passed++;
            idx++;
        end
    endtask

    task automatic test_impulse();
        logic [WIDTH:0] a, e;
        int idx, n_peak;
        do_reset();
        mode = 2'd3; pat_i = 16'h0004; amp_i = 15'd64;
        tap_pre = -8'sd8; tap_main = 8'sd48; tap_post = -8'sd8;
        repeat (64) tick(1'b1);
        drain();
        n_peak = 0;
        foreach (got_q[i]) if ($signed(got_q[i][WIDTH-1:0]) == 64) n_peak++;
        checks++;
        if (n_peak != 4) $display("FAIL impulse_peaks got=%0d exp=4", n_peak); else passed++;
        checks++;
        if (got_q.size() != 64) $display("FAIL impulse_count got=%0d exp=64", got_q.size()); else passed++;
        idx = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (a !== e) $display("FAIL impulse_stream[%0d] got bit=%b out=%0d exp bit=%b out=%0d",
                                  idx, a[WIDTH], $signed(a[WIDTH-1:0]), e[WIDTH], $signed(e[WIDTH-1:0]));
            else passed++;
            idx++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mode = 2'd0; amp_i = 15'd32767;
        tap_pre = 8'sd127; tap_main = 8'sd127; tap_post = 8'sd127;
        repeat (10) tick(1'b1);
        checks++; if (out !== -16'sd32768) $display("FAIL sat_out got=%0d exp=-32768", out); else passed++;
        checks++; if (sat_o !== 1'b1) $display("FAIL sat_set got=%b exp=1", sat_o); else passed++;
        clr_sat_i = 1'b1;
        tick(1'b1);
        checks++; if (sat_o !== 1'b1) $display("FAIL sat_set_wins got=%b exp=1", sat_o); else passed++;
        tap_pre = '0; tap_main = '0; tap_post = '0;
        repeat (6) tick(1'b1);
        clr_sat_i = 1'b1;
        tick(1'b0);
        checks++; if (sat_o !== 1'b0) $display("FAIL sat_clear got=%b exp=0", sat_o); else passed++;
        checks++; if (out !== '0) $display("FAIL sat_zero_out got=%0d exp=0", out); else passed++;
        drain();
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [WIDTH:0] a, e;
        logic signed [WIDTH-1:0] v;
        int seen, idx;
        do_reset();
        mode = 2'd1; tap_main = 8'sd64; amp_i = 15'd1000;
        repeat (20) tick(1'b1);
        tick(1'b1);
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b0) seen++;
            if (i == 0) begin
                checks++; if (out !== '0) $display("FAIL rstmid_out got=%0d exp=0", out); else passed++;
                checks++; if (bit_o !== 1'b0) $display("FAIL rstmid_bit got=%b exp=0", bit_o); else passed++;
                checks++; if (sat_o !== 1'b0) $display("FAIL rstmid_sat got=%b exp=0", sat_o); else passed++;
            end
            tick(1'b0);
        end
        checks++; if (seen != 0) $display("FAIL rstmid_novalid got=%0d exp=0", seen); else passed++;
        repeat (20) tick(1'b1);
        drain();
        for (int i = 0; i < 6; i++) begin
            v = got_q[i][WIDTH-1:0];
            checks++; if (v !== -16'sd1000) $display("FAIL rstmid_head[%0d] got=%0d exp=-1000", i, v); else passed++;
        end
        checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        else passed++;
        idx = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (a !== e) $display("FAIL rstmid_stream[%0d] got bit=%b out=%0d exp bit=%b out=%0d",
                                  idx, a[WIDTH], $signed(a[WIDTH-1:0]), e[WIDTH], $signed(e[WIDTH-1:0]));
            else passed++;
            idx++;
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] a, e;
        int idx;
        do_reset();
        tap_pre  = COEF_W'($urandom_range(0, 255));
        tap_main = COEF_W'($urandom_range(0, 255));
        tap_post = COEF_W'($urandom_range(0, 255));
        amp_i    = 15'($urandom_range(0, 32767));
        for (int seg = 0; seg < 10; seg++) begin
            mode  = 2'($urandom_range(0, 3));
            pat_i = 16'($urandom_range(0, 65535));
            for (int i = 0; i < 50; i++) begin
                en = ($urandom_range(0, 7) != 0);
                tick($urandom_range(0, 3) != 0);
            end
        end
        en = 1'b1;
        drain();
        checks++;
        if (sat_o !== logic'(msat)) $display("FAIL b2b_sat got=%b exp=%b", sat_o, msat); else passed++;
        checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        else passed++;
        idx = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (a !== e) $display("FAIL b2b_stream[%0d] got bit=%b out=%0d exp bit=%b out=%0d",
                                  idx, a[WIDTH], $signed(a[WIDTH-1:0]), e[WIDTH], $signed(e[WIDTH-1:0]));
            else passed++;
            idx++;
        end
    endtask

`ifdef TX_DRV_ERR_INJ_EN
    task automatic test_inject();
        logic [WIDTH:0] a, e;
        int idx;
        do_reset();
        mode = 2'd1; tap_main = 8'sd64; amp_i = 15'd1000;
        repeat (40) tick(1'b1);
        inj_i = 1'b1;
        tick(1'b0);
        inj_i = 1'b1;
        tick(1'b0);
        repeat (40) tick(1'b1);
        inj_i = 1'b1;
        tick(1'b1);
        repeat (40) tick(1'b1);
        drain();
        checks++;
        if (got_q.size() != exp_q.size()) $display("FAIL inj_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        else passed++;
        idx = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            a = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (a !== e) $display("FAIL inj_stream[%0d] got bit=%b out=%0d exp bit=%b out=%0d",
                                  idx, a[WIDTH], $signed(a[WIDTH-1:0]), e[WIDTH], $signed(e[WIDTH-1:0]));
            else passed++;
            idx++;
        end
    endtask
`endif

    initial begin
        rst = 1'b1; cke = 1'b0; en = 1'b0; mode = 2'd0; pat_i = 16'h0; amp_i = '0;
        tap_pre = '0; tap_main = '0; tap_post = '0; clr_sat_i = 1'b0; inj_i = 1'b0;
        model_reset();
        test_reset();
        test_prbs7();
        test_pattern();
        test_impulse();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
`ifdef TX_DRV_ERR_INJ_EN
        test_inject();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
